mips_fetch_queue: RTL

Instruction-fetch front end for the 5-stage MIPS pipeline. It owns the fetch PC, issues word requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small prefetch queue. It presents {PC+4, IR} pairs to the IF/ID latch under decode back-pressure. Branch/jump redirects flush the queue and discard in-flight responses.

---
 rtl/mips_fetch_queue_if.sv | 34 +++
 rtl/mips_fetch_queue.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue_if.sv
// rtl/mips_fetch_queue_if.sv - instruction-memory request/response bus for the fetch queue
//
// Purpose: groups the fetch-side instruction-memory handshake into one bundle.
// Signals:
//   imem_req_valid  fetch request valid (driven by fetch unit)
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   byte address of the requested word
//   imem_rsp_valid  in-order instruction word returned
//   imem_rsp_data   returned instruction word
// Modports: master = fetch unit, slave = instruction memory.

interface mips_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// rtl/mips_fetch_queue.sv - MIPS instruction-fetch front end with prefetch queue
//
// Purpose: owns the fetch PC, issues word requests to instruction memory,
// buffers in-order responses as {PC+4, IR} pairs and presents the head to the
// IF/ID latch. A redirect flushes the queue and discards in-flight responses.
// Ports:
//   clock        pipeline clock
//   reset_n      synchronous active-low reset
//   imem         instruction-memory bus (master side)
//   if_valid     queue head valid
//   if_pc4       PC+4 of head (0 when empty)
//   if_ir        head instruction (0 when empty)
//   id_stall     decode refuses the head this cycle
//   redirect     taken branch/jump: flush and refetch
//   redirect_pc  new fetch PC (bits [1:0] ignored)
//   occupancy    number of valid queue entries

module mips_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  mips_fetch_queue_if.master       imem,
  output logic                     if_valid,
  output logic [31:0]              if_pc4,
  output logic [31:0]              if_ir,
  input  logic                     id_stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_q_pc4 [DEPTH];
  logic [31:0]   r_q_ir  [DEPTH];
  logic [31:0]   r_tag   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_tag_rd;
  logic [AW-1:0] r_tag_wr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;

  logic          w_credit;
  logic          w_req_fire;
  logic          w_rsp;
  logic          w_keep;
  logic          w_pop;
  logic [31:0]   w_pc_next;
  logic          w_unused;

  // Credit uses registered counts only, so a pop never frees a slot in the
  // same cycle; this keeps the request path free of decode timing.
  assign w_credit   = ({1'b0, r_outst} + {1'b0, r_occ}) < LP_DEPTH;
  assign imem.imem_req_valid = reset_n & ~redirect & w_credit;
  assign imem.imem_req_addr  = r_fetch_pc;
  assign w_req_fire = imem.imem_req_valid & imem.imem_req_ready;
  assign w_rsp      = imem.imem_rsp_valid;
  // A response in a redirect cycle, or while stale responses remain, is discarded.
  assign w_keep     = w_rsp & ~redirect & (r_drop == '0);
  assign w_pc_next  = r_fetch_pc + 32'd4;

  assign if_valid   = (r_occ != '0);
  assign w_pop      = if_valid & ~id_stall & ~redirect;
  assign if_pc4     = if_valid ? r_q_pc4[r_rd_ptr] : 32'h0000_0000;
  assign if_ir      = if_valid ? r_q_ir[r_rd_ptr]  : 32'h0000_0000;
  assign occupancy  = r_occ;
  assign w_unused   = ^redirect_pc[1:0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
      r_occ      <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
    end else begin
      // The tag FIFO and outstanding count follow the memory, redirect or not,
      // so tags stay aligned with responses that are later dropped.
      if (w_req_fire) begin
        r_tag[r_tag_wr] <= w_pc_next;
        r_tag_wr        <= r_tag_wr + AW'(1);
      end
      if (w_rsp) begin
        r_tag_rd <= r_tag_rd + AW'(1);
      end
      r_outst <= r_outst + CW'(w_req_fire) - CW'(w_rsp);

      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_occ      <= '0;
        // Everything still in flight after this cycle belongs to the old stream.
        r_drop     <= r_outst - CW'(w_rsp);
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= w_pc_next;
        end
        if (w_rsp && (r_drop != '0)) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_keep) begin
          r_q_pc4[r_wr_ptr] <= r_tag[r_tag_rd];
          r_q_ir[r_wr_ptr]  <= imem.imem_rsp_data;
          r_wr_ptr          <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_occ <= r_occ + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

endmodule
